// File: rtl/register_status_file.sv
`default_nettype none
// ============================================================================
// Module      : register_status_file
// Description : Architectural register file with per-register busy flag and
//               ROB tag (register status for a Tomasulo-style OoO core).
//               Zero-latency reads with commit bypass, issue marks a register
//               pending, commit retires it only when the tag still matches,
//               roll_back clears every pending mark.
// Revision    : 1.0 - initial release
// ============================================================================
module register_status_file (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_entry,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_value,
    output logic [31:0] rs2_value,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [4:0]  rs1_tag,
    output logic [4:0]  rs2_tag,
    input  logic        rob_commit,
    input  logic [4:0]  rob_des_commit,
    input  logic [4:0]  rob_entry_commit,
    input  logic [31:0] rob_result_out
);

    localparam int NUM_REGS = 32;

    logic [31:0] value_q [NUM_REGS];
    logic [31:0] value_d [NUM_REGS];
    logic        busy_q  [NUM_REGS];
    logic        busy_d  [NUM_REGS];
    logic [4:0]  tag_q   [NUM_REGS];
    logic [4:0]  tag_d   [NUM_REGS];

    logic w_commit_hit;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A commit retires the pending mark only if the register still waits on
    // exactly that ROB entry; a later re-issue makes the commit stale.
    assign w_commit_hit = rob_commit && (rob_des_commit != 5'd0) &&
                          busy_q[rob_des_commit] &&
                          (tag_q[rob_des_commit] == rob_entry_commit);

    assign w_rs1_hit = w_commit_hit && (rs1_addr == rob_des_commit);
    assign w_rs2_hit = w_commit_hit && (rs2_addr == rob_des_commit);

    // Next-state: commit value write, matching-tag busy clear, then issue
    // (issue applied last so it wins over a same-register commit), roll_back
    // drops all pending marks and suppresses the issue.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            value_d[i] = value_q[i];
            busy_d[i]  = busy_q[i];
            tag_d[i]   = tag_q[i];
        end
        if (rob_commit && (rob_des_commit != 5'd0)) begin
            value_d[rob_des_commit] = rob_result_out;
        end
        if (w_commit_hit) begin
            busy_d[rob_des_commit] = 1'b0;
        end
        if (roll_back) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_d[i] = 1'b0;
            end
        end else if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_entry;
        end
    end

    // State register: asynchronous clear, updates only while not paused.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= 32'd0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= 5'd0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= value_d[i];
                busy_q[i]  <= busy_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    // Source port 1: x0 tied off, otherwise stored state with commit bypass.
    always_comb begin
        rs1_value = 32'd0;
        rs1_busy  = 1'b0;
        rs1_tag   = 5'd0;
        if (rs1_addr != 5'd0) begin
            rs1_value = w_rs1_hit ? rob_result_out : value_q[rs1_addr];
            rs1_busy  = w_rs1_hit ? 1'b0 : busy_q[rs1_addr];
            rs1_tag   = tag_q[rs1_addr];
        end
    end

    // Source port 2: identical to port 1.
    always_comb begin
        rs2_value = 32'd0;
        rs2_busy  = 1'b0;
        rs2_tag   = 5'd0;
        if (rs2_addr != 5'd0) begin
            rs2_value = w_rs2_hit ? rob_result_out : value_q[rs2_addr];
            rs2_busy  = w_rs2_hit ? 1'b0 : busy_q[rs2_addr];
            rs2_tag   = tag_q[rs2_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_status_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_status_file
// Description : Scoreboard bench for register_status_file. Stimulus pushes
//               hand-computed read expectations; a monitor pops and compares
//               them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_status_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_entry;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;
    logic        rob_commit;
    logic [4:0]  rob_des_commit;
    logic [4:0]  rob_entry_commit;
    logic [31:0] rob_result_out;

    register_status_file dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .roll_back       (roll_back),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_entry     (issue_entry),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_value       (rs1_value),
        .rs2_value       (rs2_value),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rs1_tag         (rs1_tag),
        .rs2_tag         (rs2_tag),
        .rob_commit      (rob_commit),
        .rob_des_commit  (rob_des_commit),
        .rob_entry_commit(rob_entry_commit),
        .rob_result_out  (rob_result_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [31:0] v1;
        logic        b1;
        logic [4:0]  t1;
        logic        ct1;
        logic [31:0] v2;
        logic        b2;
        logic [4:0]  t2;
        logic        ct2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Tag is only meaningful when busy; x0 must read tag 0 as well.
    task automatic expect_rd(input string n,
                             input logic [31:0] v1, input logic b1, input logic [4:0] t1,
                             input logic [31:0] v2, input logic b2, input logic [4:0] t2);
        exp_t e;
        e.name = n;
        e.v1 = v1; e.b1 = b1; e.t1 = t1; e.ct1 = b1 || (rs1_addr == 5'd0);
        e.v2 = v2; e.b2 = b2; e.t2 = t2; e.ct2 = b2 || (rs2_addr == 5'd0);
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic iv, input logic [4:0] rd, input logic [4:0] ent,
                       input logic cm, input logic [4:0] des, input logic [4:0] cent,
                       input logic [31:0] res, input logic rb,
                       input logic [4:0] a1, input logic [4:0] a2);
        issue_valid      = iv;
        issue_rd         = rd;
        issue_entry      = ent;
        rob_commit       = cm;
        rob_des_commit   = des;
        rob_entry_commit = cent;
        rob_result_out   = res;
        roll_back        = rb;
        rs1_addr         = a1;
        rs2_addr         = a2;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: read ports are combinational, so the falling edge is the
    // point where each cycle's outputs are presented for checking.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk_in);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                bad = (rs1_value !== e.v1) || (rs1_busy !== e.b1) ||
                      (e.ct1 && (rs1_tag !== e.t1)) ||
                      (rs2_value !== e.v2) || (rs2_busy !== e.b2) ||
                      (e.ct2 && (rs2_tag !== e.t2));
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got rs1=%h/%b/%0d rs2=%h/%b/%0d, want rs1=%h/%b/%0d rs2=%h/%b/%0d",
                             e.name, rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag,
                             e.v1, e.b1, e.t1, e.v2, e.b2, e.t2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        next_cycle();
        // Held in reset
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
        expect_rd("reset_state", 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_in = 1'b1;

        // Issue x5/entry3; same-cycle read still sees the old state
        drv(1, 5, 3, 0, 0, 0, 0, 0, 5, 0);
        expect_rd("issue_same_cycle", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
        expect_rd("issue_then_read", 0, 1, 3, 0, 0, 0);
        next_cycle();

        // Commit bypass
        drv(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 0);
        expect_rd("commit_bypass", 32'hDEADBEEF, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_rd("commit_stored", 32'hDEADBEEF, 0, 0, 0, 0, 0);
        next_cycle();

        // Stale commit: x5 reissued with tag 7 before entry 3 commits
        drv(1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(1, 5, 7, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 1, 5, 3, 32'h11, 0, 5, 0);
        expect_rd("stale_no_bypass", 32'hDEADBEEF, 1, 7, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_rd("stale_stored", 32'h11, 1, 7, 0, 0, 0);
        next_cycle();

        // Same-cycle issue and commit on x6
        drv(1, 6, 2, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(1, 6, 9, 1, 6, 2, 32'h42, 0, 5, 6);
        expect_rd("issue_commit_read", 32'h11, 1, 7, 32'h42, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        expect_rd("issue_wins", 0, 0, 0, 32'h42, 1, 9);
        next_cycle();

        // Paused: outputs track inputs, nothing is stored
        rdy_in = 1'b0;
        drv(1, 7, 4, 1, 6, 9, 32'h55, 0, 6, 7);
        expect_rd("pause_bypass", 32'h55, 0, 0, 0, 0, 0);
        next_cycle();
        rdy_in = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 6, 7);
        expect_rd("pause_held", 32'h42, 1, 9, 0, 0, 0);
        next_cycle();

        // x1..x4 pending on entries 10..13
        for (int i = 1; i <= 4; i++) begin
            drv(1, 5'(i), 5'(9 + i), 0, 0, 0, 0, 0, 0, 0);
            next_cycle();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        expect_rd("multi_busy", 0, 1, 10, 0, 1, 13);
        next_cycle();

        // roll_back with issue of x8 and a commit to x2
        drv(1, 8, 14, 1, 2, 11, 32'h77, 1, 2, 3);
        expect_rd("rollback_cycle", 32'h77, 0, 0, 0, 1, 12);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2, 8);
        expect_rd("rollback_x2_x8", 32'h77, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        expect_rd("rollback_x1_x6", 0, 0, 0, 32'h42, 0, 0);
        next_cycle();

        // x0 ignores commit and issue
        drv(1, 0, 5, 1, 0, 0, 32'hFF, 0, 0, 0);
        expect_rd("x0_cycle", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_rd("x0_after", 0, 0, 0, 0, 0, 0);
        next_cycle();

        // Asynchronous reset mid-cycle with issue and commit in flight
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 9, 6);
        expect_rd("pre_reset", 0, 1, 1, 32'h42, 0, 0);
        next_cycle();
        drv(1, 10, 4, 1, 9, 1, 32'h99, 0, 9, 6);
        #2;
        rst_in = 1'b0;
        expect_rd("async_reset", 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_in = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 10, 9);
        expect_rd("post_reset", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(1, 3, 2, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 6);
        expect_rd("post_reset_issue", 0, 1, 2, 0, 0, 0);
        next_cycle();

        next_cycle();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_status_file.md
REGISTER_STATUS_FILE -- requirements
Module: register_status_file

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port rdy_in, input, 1, pause; when low, all state holds.
REQ-004 SHALL have port roll_back, input, 1, mispredict flush from the commit stage.
REQ-005 SHALL have port issue_valid, input, 1, an instruction is issuing this cycle.
REQ-006 SHALL have port issue_rd, input, 5, destination register of the issuing instruction.
REQ-007 SHALL have port issue_entry, input, 5, ROB entry allocated to the issuing instruction.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, 5 each, source register indices of the decoding instruction.
REQ-009 SHALL have ports rs1_value and rs2_value, output, 32 each, source operand value.
REQ-010 SHALL have ports rs1_busy and rs2_busy, output, 1 each, the operand is pending in the ROB.
REQ-011 SHALL have ports rs1_tag and rs2_tag, output, 5 each, ROB entry producing the pending operand.
REQ-012 SHALL have port rob_commit, input, 1, commit broadcast valid.
REQ-013 SHALL have port rob_des_commit, input, 5, committed destination register.
REQ-014 SHALL have port rob_entry_commit, input, 5, ROB entry being committed.
REQ-015 SHALL have port rob_result_out, input, 32, committed result value.

Function
REQ-016 SHALL hold 32 architectural registers x0..x31, each with a 32-bit value, a 1-bit busy flag and a 5-bit tag.
REQ-017 SHALL write, on a commit edge (rob_commit=1, rdy_in=1), rob_result_out into value[rob_des_commit] when rob_des_commit != 0.
REQ-018 SHALL clear busy[rob_des_commit] on a commit edge only when that register is busy and tag[rob_des_commit] == rob_entry_commit; otherwise busy and tag are unchanged.
REQ-019 SHALL, on an issue edge (issue_valid=1, rdy_in=1, roll_back=0) with issue_rd != 0, set busy[issue_rd]=1 and tag[issue_rd]=issue_entry.
REQ-020 SHALL let issue win when issue and commit target the same register in one cycle: the value is written, busy ends at 1, and tag ends at issue_entry.
REQ-021 SHALL produce read outputs combinationally (zero latency) from the current state plus commit bypass.
REQ-022 SHALL bypass commits: if rob_commit=1, rsN_addr == rob_des_commit != 0, and the register is busy with tag == rob_entry_commit, then rsN_value=rob_result_out, rsN_busy=0, and rsN_tag=don't-care.
REQ-023 SHALL let a same-cycle issue never affect that cycle's read outputs; reads reflect state before the issue.
REQ-024 SHALL tie x0 off: rsN_addr=0 gives value 0, busy 0, tag 0; writes and issues to x0 are ignored.
REQ-025 SHALL, on a roll_back edge (rdy_in=1), clear all busy flags and ignore issue_valid, while still applying a same-cycle commit value write.
REQ-026 SHALL, with rdy_in=0, change no state; combinational outputs still track the inputs.
REQ-027 SHALL not drive rsN_busy=1 when the register is not busy; tag outputs are valid only when busy=1.

Reset
REQ-028 SHALL, while rst_in=0, immediately and asynchronously clear all values, busy flags and tags to 0, independent of clk_in and rdy_in.
REQ-029 SHALL abandon any in-flight issue or commit when rst_in falls between edges; the next edge after rst_in rises operates on the all-zero state.
REQ-030 SHALL read all sources as value 0, busy 0 immediately after reset.

Verification
REQ-031 SHALL cover issue then read: issue rd=5, entry=3 -> next cycle rs1_addr=5 gives busy=1, tag=3.
REQ-032 SHALL cover commit bypass: with x5 busy tag 3, commit des=5, entry=3, result=0xDEADBEEF -> same cycle rs1_value=0xDEADBEEF, busy=0; next cycle stored value=0xDEADBEEF, busy=0.
REQ-033 SHALL cover stale commit: x5 reissued with tag 7, then commit des=5, entry=3, result=0x11 -> value=0x11, busy stays 1, tag=7, and there is no bypass.
REQ-034 SHALL cover same-cycle issue and commit: x6 busy tag 2, commit entry 2 result 0x42 plus issue rd=6 entry 9 -> value=0x42, busy=1, tag=9; the read that cycle shows 0x42, busy=0.
REQ-035 SHALL cover roll_back: x1..x4 busy, roll_back=1 with issue_valid=1 rd=8 -> all busy=0, x8 not busy.
REQ-036 SHALL cover x0 and reset: commit des=0 result 0xFF and issue rd=0 -> x0 reads 0, busy 0; pulse rst_in low mid-cycle -> all registers read 0 without a clock edge.
